// File: rtl/phivers_inj_rx_pkg.sv
// Shared types and constants for the Phivers injector receive endpoint.
package phivers_inj_rx_pkg;

   typedef enum logic [1:0] {
      HEADER  = 2'd0,
      SIZE    = 2'd1,
      PAYLOAD = 2'd2
   } inj_rx_state_t;

   localparam int unsigned INJ_RX_BUFFER_SIZE = 8;

endpackage : phivers_inj_rx_pkg

// File: rtl/phivers_inj_rx_fifo.sv
// Circular credit FIFO. Pointers carry one extra MSB to tell full from empty.
module phivers_inj_rx_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             credit_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   ptr_t             wr_q, wr_d, rd_q, rd_d;
   logic             credit_q, credit_d;
   logic             push, pop, full_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign empty_o  = (wr_q == rd_q);
   assign head_o   = mem_q[rd_q[AW-1:0]];
   assign credit_o = credit_q;

   // Credit is computed from next-state fullness so the edge that fills the
   // buffer also withdraws credit; a push can therefore never overflow.
   always_comb begin
      push     = push_i && credit_q;
      pop      = pop_i && !empty_o;
      wr_d     = wr_q + ptr_t'(push);
      rd_d     = rd_q + ptr_t'(pop);
      full_d   = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      credit_d = !full_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q     <= '0;
         rd_q     <= '0;
         credit_q <= 1'b1;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         credit_q <= credit_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

endmodule : phivers_inj_rx_fifo

// File: rtl/phivers_inj_rx.sv
// Phivers injector receive endpoint: buffers router flits, frames packets
// (header/size/payload) onto a valid/ready stream and counts packets/errors.
module phivers_inj_rx
   import phivers_inj_rx_pkg::*;
#(
   parameter int unsigned FLIT_SIZE   = 32,
   parameter int unsigned BUFFER_SIZE = INJ_RX_BUFFER_SIZE,
   parameter logic [15:0] INJ_ADDR    = 16'h0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [FLIT_SIZE-1:0] out_data_o,
   output logic                 out_sop_o,
   output logic                 out_eop_o,
   output logic                 addr_err_o,
   output logic [31:0]          pkt_cnt_o,
   output logic [15:0]          err_cnt_o
);

   inj_rx_state_t        state_q, state_d;
   logic [FLIT_SIZE-1:0] rem_q, rem_d;
   logic [31:0]          pkt_q, pkt_d;
   logic [15:0]          err_q, err_d;
   logic                 addr_err_q, addr_err_d;
   logic [FLIT_SIZE-1:0] head;
   logic                 empty, pop, eop_raw;

   phivers_inj_rx_fifo #(
      .WIDTH (FLIT_SIZE),
      .DEPTH (BUFFER_SIZE)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (rx_i),
      .data_i   (data_i),
      .pop_i    (out_ready_i),
      .head_o   (head),
      .credit_o (credit_o),
      .empty_o  (empty)
   );

   assign out_valid_o = !empty;
   assign out_data_o  = out_valid_o ? head : '0;
   assign pop         = out_valid_o && out_ready_i;
   assign eop_raw     = ((state_q == SIZE) && (head == '0)) ||
                        ((state_q == PAYLOAD) && (rem_q == FLIT_SIZE'(1)));
   assign out_sop_o   = out_valid_o && (state_q == HEADER);
   assign out_eop_o   = out_valid_o && eop_raw;
   assign addr_err_o  = addr_err_q;
   assign pkt_cnt_o   = pkt_q;
   assign err_cnt_o   = err_q;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      addr_err_d = 1'b0;
      if (pop) begin
         case (state_q)
            HEADER: begin
               if (head[15:0] != INJ_ADDR) begin
                  addr_err_d = 1'b1;
                  if (err_q != '1) err_d = err_q + 16'd1;
               end
               state_d = SIZE;
            end
            SIZE: begin
               rem_d = head;
               if (head == '0) begin
                  pkt_d   = pkt_q + 32'd1;
                  state_d = HEADER;
               end else begin
                  state_d = PAYLOAD;
               end
            end
            PAYLOAD: begin
               rem_d = rem_q - FLIT_SIZE'(1);
               if (rem_q == FLIT_SIZE'(1)) begin
                  pkt_d   = pkt_q + 32'd1;
                  state_d = HEADER;
               end
            end
            default: state_d = HEADER;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= HEADER;
         rem_q      <= '0;
         pkt_q      <= '0;
         err_q      <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
         addr_err_q <= addr_err_d;
      end
   end

endmodule : phivers_inj_rx

// File: tb/tb_phivers_inj_rx.sv
// Directed bench for phivers_inj_rx with INJ_ADDR = 16'h0101.
module tb_phivers_inj_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b0;
   logic        ready = 1'b0;
   logic [31:0] din = '0;
   logic        credit, valid, sop, eop, addr_err;
   logic [31:0] dout, pkt_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] f [28];

   always #5 clk = ~clk;

   phivers_inj_rx #(
      .FLIT_SIZE   (32),
      .BUFFER_SIZE (8),
      .INJ_ADDR    (16'h0101)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_i        (rx),
      .data_i      (din),
      .credit_o    (credit),
      .out_valid_o (valid),
      .out_ready_i (ready),
      .out_data_o  (dout),
      .out_sop_o   (sop),
      .out_eop_o   (eop),
      .addr_err_o  (addr_err),
      .pkt_cnt_o   (pkt_cnt),
      .err_cnt_o   (err_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wi, ri;
      logic acc, popped;

      // reset state
      tick; tick;
      chk("rst_valid", valid, 0);
      chk("rst_sop", sop, 0);
      chk("rst_eop", eop, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_data", dout, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_err", err_cnt, 0);
      rst = 1'b0;
      tick;
      chk("rst_credit", credit, 1);

      // single packet, size 3, ready=1
      ready = 1'b1; rx = 1'b1; din = 32'h0000_0101;
      tick;
      chk("p1_hdr_valid", valid, 1);
      chk("p1_hdr_data", dout, 32'h0000_0101);
      chk("p1_hdr_sop", sop, 1);
      chk("p1_hdr_eop", eop, 0);
      din = 32'd3;
      tick;
      chk("p1_size_data", dout, 3);
      chk("p1_size_sop", sop, 0);
      chk("p1_no_addr_err", addr_err, 0);
      din = 32'hAAAA_0001;
      tick;
      chk("p1_a_data", dout, 32'hAAAA_0001);
      chk("p1_a_eop", eop, 0);
      din = 32'hAAAA_0002;
      tick;
      chk("p1_b_data", dout, 32'hAAAA_0002);
      chk("p1_b_eop", eop, 0);
      din = 32'hAAAA_0003;
      tick;
      chk("p1_c_data", dout, 32'hAAAA_0003);
      chk("p1_c_eop", eop, 1);
      rx = 1'b0;
      tick;
      chk("p1_drained", valid, 0);
      chk("p1_pkt", pkt_cnt, 1);
      chk("p1_err", err_cnt, 0);

      // zero-payload packet
      rx = 1'b1; din = 32'h0000_0101;
      tick;
      din = 32'd0;
      tick;
      chk("p2_size_eop", eop, 1);
      chk("p2_size_sop", sop, 0);
      chk("p2_size_data", dout, 0);
      rx = 1'b0;
      tick;
      chk("p2_pkt", pkt_cnt, 2);
      chk("p2_drained", valid, 0);
      chk("p2_empty_sop", sop, 0);

      // backpressure: 10-flit packet with ready low
      ready = 1'b0;
      f[0] = 32'h0000_0101; f[1] = 32'd8;
      for (int i = 2; i < 10; i++) f[i] = 32'h3000_0000 + 32'(i);
      for (int i = 0; i < 8; i++) begin
         rx = 1'b1; din = f[i];
         tick;
      end
      chk("bp_credit_full", credit, 0);
      chk("bp_head", dout, f[0]);
      chk("bp_head_sop", sop, 1);
      din = f[8];
      tick;
      chk("bp_credit_hold", credit, 0);
      chk("bp_head_stable", dout, f[0]);
      ready = 1'b1;
      tick;
      chk("bp_credit_back", credit, 1);
      chk("bp_f1", dout, f[1]);
      tick;
      chk("bp_f2", dout, f[2]);
      din = f[9];
      tick;
      rx = 1'b0;
      for (int j = 3; j < 10; j++) begin
         chk("bp_order", dout, f[j]);
         chk("bp_eop", eop, (j == 9) ? 32'd1 : 32'd0);
         tick;
      end
      chk("bp_drained", valid, 0);
      chk("bp_pkt", pkt_cnt, 3);
      chk("bp_credit_end", credit, 1);

      // address mismatch: header target 0000 vs 0101
      rx = 1'b1; din = 32'h0000_0000;
      tick;
      chk("mm_sop", sop, 1);
      chk("mm_no_pulse_yet", addr_err, 0);
      din = 32'd1;
      tick;
      chk("mm_pulse", addr_err, 1);
      chk("mm_err_cnt", err_cnt, 1);
      chk("mm_size_data", dout, 1);
      din = 32'hDDDD_0000;
      tick;
      chk("mm_pulse_once", addr_err, 0);
      chk("mm_payload_eop", eop, 1);
      chk("mm_payload_data", dout, 32'hDDDD_0000);
      rx = 1'b0;
      tick;
      chk("mm_pkt", pkt_cnt, 4);
      chk("mm_err_hold", err_cnt, 1);
      chk("mm_drained", valid, 0);

      // sustained push/pop through a full buffer, pointers wrap several times
      ready = 1'b0;
      f[0] = 32'h0000_0101; f[1] = 32'd26;
      for (int i = 2; i < 28; i++) f[i] = 32'h5000_0000 + 32'(i);
      for (int i = 0; i < 8; i++) begin
         rx = 1'b1; din = f[i];
         tick;
      end
      chk("st_credit_full", credit, 0);
      ready = 1'b1;
      wi = 8; ri = 0;
      for (int c = 0; c < 80 && ri < 28; c++) begin
         rx  = (wi < 28);
         din = (wi < 28) ? f[wi] : 32'd0;
         if (valid) begin
            chk("st_order", dout, f[ri]);
            chk("st_sop", sop, (ri == 0) ? 32'd1 : 32'd0);
            chk("st_eop", eop, (ri == 27) ? 32'd1 : 32'd0);
         end
         acc    = rx && credit;
         popped = valid;
         tick;
         if (acc) wi++;
         if (popped) ri++;
      end
      rx = 1'b0;
      chk("st_all_out", 32'(ri), 28);
      chk("st_pkt", pkt_cnt, 5);
      chk("st_credit_end", credit, 1);
      chk("st_drained", valid, 0);

      // reset mid-payload with flits still buffered
      rx = 1'b1; din = 32'h0000_0101;
      tick;
      din = 32'd5;
      tick;
      din = 32'h6000_0000;
      tick;
      ready = 1'b0; din = 32'h6000_0001;
      tick;
      rx = 1'b0;
      chk("rm_pre_valid", valid, 1);
      chk("rm_pre_data", dout, 32'h6000_0000);
      #2 rst = 1'b1;
      #1;
      chk("rm_valid", valid, 0);
      chk("rm_data", dout, 0);
      chk("rm_pkt", pkt_cnt, 0);
      chk("rm_err", err_cnt, 0);
      chk("rm_eop", eop, 0);
      tick;
      rst = 1'b0;
      tick;
      chk("rm_credit", credit, 1);
      ready = 1'b1; rx = 1'b1; din = 32'h0000_0101;
      tick;
      chk("rm_new_sop", sop, 1);
      din = 32'd1;
      tick;
      chk("rm_new_size_sop", sop, 0);
      chk("rm_new_size_eop", eop, 0);
      din = 32'h0000_0077;
      tick;
      chk("rm_new_eop", eop, 1);
      chk("rm_new_data", dout, 32'h0000_0077);
      rx = 1'b0;
      tick;
      chk("rm_new_pkt", pkt_cnt, 1);
      chk("rm_new_drained", valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_phivers_inj_rx
